pdecoder_3to5_acc: RTL

PDECODER_3TO5_ACC -- requirements
Module: pdecoder_3to5_acc

---
 rtl/pdecoder_pkg.sv | 16 +
 rtl/idx2onehot_3to5.sv | 27 ++
 rtl/pdecoder_3to5_acc.sv | 101 ++++++++++
 3 files changed

// File: rtl/pdecoder_pkg.sv
// Shared widths and FSM encoding for the 3-to-5 position decoder/accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pdecoder_pkg;

    localparam int MASK_W = 5;
    localparam int IDX_W  = 3;
    localparam int CNT_W  = 3;

    // ACCUM collects beats of a group; HOLD presents the rebuilt group downstream.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage : pdecoder_pkg

// File: rtl/idx2onehot_3to5.sv
// Converts an MSB-first bit position (0 = mask bit 4) into a 5-bit one-hot.
// Latency: combinational.
// Backpressure: none.
// Ports: idx - bit position; onehot - decoded bit (zero when out of range);
//        in_range - idx is 0..4.
module idx2onehot_3to5
    import pdecoder_pkg::*;
(
    input  logic [IDX_W-1:0]  idx,
    output logic [MASK_W-1:0] onehot,
    output logic              in_range
);

    always_comb begin
        onehot   = '0;
        in_range = 1'b1;
        case (idx)
            3'd0:    onehot = 5'b10000;
            3'd1:    onehot = 5'b01000;
            3'd2:    onehot = 5'b00100;
            3'd3:    onehot = 5'b00010;
            3'd4:    onehot = 5'b00001;
            default: in_range = 1'b0;
        endcase
    end

endmodule : idx2onehot_3to5

// File: rtl/pdecoder_3to5_acc.sv
// Rebuilds a 5-bit mask, set-bit count and dup/err flags from a stream of index beats.
// Latency: group presented 1 cycle after the beat carrying in_last.
// Backpressure: in_rdy low while the group is held; held until out_rdy, no beats taken meanwhile.
// Ports: clk/reset (sync, active-high); in_val/in_rdy/in_idx/in_nz/in_last - beat stream;
//        out_val/out_rdy/out_mask/out_cnt/out_dup/out_err - rebuilt group.
module pdecoder_3to5_acc
    import pdecoder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_val,
    output logic              in_rdy,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic              in_nz,
    input  logic              in_last,
    output logic              out_val,
    input  logic              out_rdy,
    output logic [MASK_W-1:0] out_mask,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_dup,
    output logic              out_err
);

    state_t              state_q, state_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                dup_q, dup_d;
    logic                err_q, err_d;

    logic [MASK_W-1:0]   onehot;
    logic                in_range;
    logic                beat_acc;

    idx2onehot_3to5 u_dec (
        .idx      (in_idx),
        .onehot   (onehot),
        .in_range (in_range)
    );

    assign in_rdy   = (state_q == ACCUM);
    assign out_val  = (state_q == HOLD);
    assign beat_acc = in_val && in_rdy;

    assign out_mask = mask_q;
    assign out_cnt  = cnt_q;
    assign out_dup  = dup_q;
    assign out_err  = err_q;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        dup_d   = dup_q;
        err_d   = err_q;

        if (state_q == ACCUM) begin
            if (beat_acc) begin
                // in_nz = 0 is an empty-group marker: only in_last matters.
                if (in_nz) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else if ((mask_q & onehot) != '0) begin
                        // Repeated position: flag it but do not count it twice.
                        dup_d = 1'b1;
                    end else begin
                        mask_d = mask_q | onehot;
                        cnt_d  = cnt_q + 3'd1;
                    end
                end
                if (in_last) begin
                    state_d = HOLD;
                end
            end
        end else begin
            if (out_rdy) begin
                state_d = ACCUM;
                mask_d  = '0;
                cnt_d   = '0;
                dup_d   = 1'b0;
                err_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCUM;
            mask_q  <= '0;
            cnt_q   <= '0;
            dup_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            dup_q   <= dup_d;
            err_q   <= err_d;
        end
    end

endmodule : pdecoder_3to5_acc
